// File: rtl/ram_be_dp.sv
// ram_be_dp: true dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write behaviour, and an optional output register.
// Port A is the load/store side and port B is the fetch/debug-loader side.
// Where both ports write the same byte in one cycle, port A wins.

// Per-port output pipeline: stage 1 captures the read word, and stage 2 is optional.
module ram_be_dp_port #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,     // request accepted this edge
    input  logic                  i_hold,   // request produces no data (no-change write)
    input  logic [DATA_WIDTH-1:0] i_rdata,  // word this request returns
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_vld_q, s1_vld_d;

    // Stage-1 next state: load on a data-producing request, otherwise hold data.
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = 1'b0;
        if (i_en && !i_hold) begin
            s1_data_d = i_rdata;
            s1_vld_d  = 1'b1;
        end
    end

    // Stage-1 registers. They are cleared asynchronously so in-flight results are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_vld_q;

        // Stage 2 follows stage 1 only when stage 1 holds a real result.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                if (s1_vld_q) s2_data_q <= s1_data_q;
                s2_vld_q <= s1_vld_q;
            end
        end

        assign o_data  = s2_data_q;
        assign o_valid = s2_vld_q;
    end else begin : g_noreg
        assign o_data  = s1_data_q;
        assign o_valid = s1_vld_q;
    end
endmodule

module ram_be_dp #(
    parameter int DEPTH      = 2**16,
    parameter int DATA_WIDTH = 32,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en_a,
    input  logic [$clog2(DEPTH)-1:0]  i_addr_a,
    input  logic [DATA_WIDTH-1:0]     i_data_a,
    input  logic [DATA_WIDTH/8-1:0]   i_be_a,
    output logic [DATA_WIDTH-1:0]     o_data_a,
    output logic                      o_valid_a,
    input  logic                      i_en_b,
    input  logic [$clog2(DEPTH)-1:0]  i_addr_b,
    input  logic [DATA_WIDTH-1:0]     i_data_b,
    input  logic [DATA_WIDTH/8-1:0]   i_be_b,
    output logic [DATA_WIDTH-1:0]     o_data_b,
    output logic                      o_valid_b,
    output logic                      o_collision
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);

    // The array has no reset, so its contents survive i_rst_n.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Index 0 is port A and index 1 is port B.
    logic [1:0]                 en, wr, hold;
    logic [1:0][AW-1:0]         addr;
    logic [1:0][NB-1:0]         be;
    logic [1:0][DATA_WIDTH-1:0] wdata, old_w, fin_w, rsel_w, data_o;
    logic [1:0]                 vld_o;
    logic                       same;
    logic                       coll_d, coll1_q;

    assign en    = {i_en_b, i_en_a};
    assign addr  = {i_addr_b, i_addr_a};
    assign be    = {i_be_b, i_be_a};
    assign wdata = {i_data_b, i_data_a};
    assign same  = (i_addr_a == i_addr_b);

    assign wr[0]  = en[0] & (|be[0]);
    assign wr[1]  = en[1] & (|be[1]);
    assign coll_d = en[0] & en[1] & same & (wr[0] | wr[1]);

    // Pre-edge contents at each port's address. Cross-port reads always see these.
    assign old_w[0] = mem_q[addr[0]];
    assign old_w[1] = mem_q[addr[1]];

    // Post-edge word at each port's address.
    // B's bytes are applied first, so that A's bytes override them.
    always_comb begin
        fin_w = old_w;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NB; k++) begin
                if (wr[1] && (p == 1 || same) && be[1][k])
                    fin_w[p][8*k +: 8] = wdata[1][8*k +: 8];
                if (wr[0] && (p == 0 || same) && be[0][k])
                    fin_w[p][8*k +: 8] = wdata[0][8*k +: 8];
            end
        end
    end

    // Data returned to each port:
    // - write-first writes see the merged word;
    // - everything else sees the old word.
    // A no-change write produces nothing.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsel_w[p] = (wr[p] && READ_MODE == 0) ? fin_w[p] : old_w[p];
            hold[p]   = wr[p] && (READ_MODE == 2);
        end
    end

    // Byte-masked array update.
    // Port B is written before port A, so A wins on shared bytes.
    // No write occurs while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int p = 1; p >= 0; p--) begin
                if (wr[p]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (be[p][k]) mem_q[addr[p]][8*k +: 8] <= wdata[p][8*k +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        ram_be_dp_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_REG    (OUT_REG)
        ) u_port (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (en[p]),
            .i_hold  (hold[p]),
            .i_rdata (rsel_w[p]),
            .o_data  (data_o[p]),
            .o_valid (vld_o[p])
        );
    end

    // Collision flag, stage 1. It moves in step with the data pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) coll1_q <= 1'b0;
        else          coll1_q <= coll_d;
    end

    if (OUT_REG != 0) begin : g_coll2
        logic coll2_q;

        // Collision flag, stage 2. It is aligned with the registered outputs.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) coll2_q <= 1'b0;
            else          coll2_q <= coll1_q;
        end

        assign o_collision = coll2_q;
    end else begin : g_coll1
        assign o_collision = coll1_q;
    end

    assign o_data_a  = data_o[0];
    assign o_valid_a = vld_o[0];
    assign o_data_b  = data_o[1];
    assign o_valid_b = vld_o[1];
endmodule

// File: tb/tb_ram_be_dp.sv
// Bench for ram_be_dp: three configurations share one stimulus stream.
// The configurations are:
//   write-first with no output register,
//   read-first with the output register,
//   no-change with no output register.
// They are checked against a transaction-level memory model.
module tb_ram_be_dp;
    localparam int DW = 32;
    localparam int DEPTH = 256;
    localparam int AW = 8;
    localparam int NB = 4;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en_a, en_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wd_a, wd_b;
    logic [NB-1:0] be_a, be_b;
    logic [DW-1:0] od_a [NI];
    logic [DW-1:0] od_b [NI];
    logic          ov_a [NI];
    logic          ov_b [NI];
    logic          oc   [NI];

    ram_be_dp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_MODE(0), .OUT_REG(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_addr_a(addr_a), .i_data_a(wd_a), .i_be_a(be_a),
        .o_data_a(od_a[0]), .o_valid_a(ov_a[0]),
        .i_en_b(en_b), .i_addr_b(addr_b), .i_data_b(wd_b), .i_be_b(be_b),
        .o_data_b(od_b[0]), .o_valid_b(ov_b[0]), .o_collision(oc[0]));
    ram_be_dp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_MODE(1), .OUT_REG(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_addr_a(addr_a), .i_data_a(wd_a), .i_be_a(be_a),
        .o_data_a(od_a[1]), .o_valid_a(ov_a[1]),
        .i_en_b(en_b), .i_addr_b(addr_b), .i_data_b(wd_b), .i_be_b(be_b),
        .o_data_b(od_b[1]), .o_valid_b(ov_b[1]), .o_collision(oc[1]));
    ram_be_dp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .READ_MODE(2), .OUT_REG(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_en_a(en_a), .i_addr_a(addr_a), .i_data_a(wd_a), .i_be_a(be_a),
        .o_data_a(od_a[2]), .o_valid_a(ov_a[2]),
        .i_en_b(en_b), .i_addr_b(addr_b), .i_data_b(wd_b), .i_be_b(be_b),
        .o_data_b(od_b[2]), .o_valid_b(ov_b[2]), .o_collision(oc[2]));

    function automatic int mode_of(int i);
        return i;
    endfunction

    function automatic int lat_of(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    // Model state. The word contents carry a known flag, because the RAM powers up undefined.
    logic [DW-1:0] rmem [DEPTH];
    bit            rknown [DEPTH];

    typedef struct packed {
        logic [1:0][DW-1:0] d;   // last data produced (held when idle)
        logic [1:0]         dk;  // data is known
        logic [1:0]         v;
        logic               c;
    } snap_t;

    snap_t cur [NI];
    snap_t prev [NI];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            cur[i]    = '0;
            cur[i].dk = 2'b11;
            prev[i]   = cur[i];
        end
    endtask

    // One rising edge: compute what each request returns, then apply the writes (B first, A wins).
    task automatic step();
        bit            en [2];
        bit            wr [2];
        bit            okn [2];
        logic [AW-1:0] ad [2];
        logic [NB-1:0] be [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] old [2];
        bit            coll;

        if (!rst_n) begin
            model_clear();
            return;
        end

        en[0] = en_a;   en[1] = en_b;
        ad[0] = addr_a; ad[1] = addr_b;
        be[0] = be_a;   be[1] = be_b;
        wd[0] = wd_a;   wd[1] = wd_b;

        for (int p = 0; p < 2; p++) begin
            wr[p]  = en[p] && (be[p] != 0);
            old[p] = rmem[ad[p]];
            okn[p] = rknown[ad[p]];
        end

        coll = en[0] && en[1] && (ad[0] == ad[1]) && (wr[0] || wr[1]);

        for (int p = 1; p >= 0; p--) begin
            if (wr[p]) begin
                for (int k = 0; k < NB; k++)
                    if (be[p][k]) rmem[ad[p]][8*k +: 8] = wd[p][8*k +: 8];
                if (be[p] == 4'hF) rknown[ad[p]] = 1'b1;
            end
        end

        for (int i = 0; i < NI; i++) begin
            prev[i]  = cur[i];
            cur[i].c = coll;
            for (int p = 0; p < 2; p++) begin
                cur[i].v[p] = 1'b0;
                if (en[p]) begin
                    if (!wr[p] || mode_of(i) == 1) begin
                        cur[i].d[p]  = old[p];
                        cur[i].dk[p] = okn[p];
                        cur[i].v[p]  = 1'b1;
                    end else if (mode_of(i) == 0) begin
                        cur[i].d[p]  = rmem[ad[p]];
                        cur[i].dk[p] = rknown[ad[p]];
                        cur[i].v[p]  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        snap_t e;
        for (int i = 0; i < NI; i++) begin
            e = (lat_of(i) == 1) ? cur[i] : prev[i];
            chk($sformatf("%s.u%0d.va", tag, i), 64'(ov_a[i]), 64'(e.v[0]));
            chk($sformatf("%s.u%0d.vb", tag, i), 64'(ov_b[i]), 64'(e.v[1]));
            chk($sformatf("%s.u%0d.col", tag, i), 64'(oc[i]), 64'(e.c));
            if (e.dk[0]) chk($sformatf("%s.u%0d.da", tag, i), 64'(od_a[i]), 64'(e.d[0]));
            if (e.dk[1]) chk($sformatf("%s.u%0d.db", tag, i), 64'(od_b[i]), 64'(e.d[1]));
        end
    endtask

    // Called at a falling edge. Drives the inputs, models the next rising edge, then checks.
    task automatic cycle(input string tag,
                         input bit ea, input logic [NB-1:0] ba, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da,
                         input bit eb, input logic [NB-1:0] bb, input logic [AW-1:0] ab,
                         input logic [DW-1:0] db);
        en_a = ea; be_a = ba; addr_a = aa; wd_a = da;
        en_b = eb; be_b = bb; addr_b = ab; wd_b = db;
        @(posedge clk);
        step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 4'h0, 8'h00, 32'h0, 0, 4'h0, 8'h00, 32'h0);
    endtask

    // Random traffic. Addresses are mostly drawn from a narrow window, to provoke collisions.
    task automatic rnd_cycle(input string tag);
        logic [AW-1:0] a0, a1;
        logic [NB-1:0] b0, b1;
        a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(8'h60, 8'h63));
        a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(8'h60, 8'h63));
        b0 = ($urandom_range(0, 9) < 4) ? 4'h0 : NB'($urandom_range(0, 15));
        b1 = ($urandom_range(0, 9) < 4) ? 4'h0 : NB'($urandom_range(0, 15));
        cycle(tag, $urandom_range(0, 3) != 0, b0, a0, $urandom(),
                   $urandom_range(0, 3) != 0, b1, a1, $urandom());
    endtask

    logic [DW-1:0] keep10;

    initial begin
        en_a = 0; en_b = 0; addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0; be_a = '0; be_b = '0;
        for (int a = 0; a < DEPTH; a++) begin
            rmem[a]   = '0;
            rknown[a] = 1'b0;
        end
        model_clear();
        @(negedge clk);

        // Requests are ignored while reset is held, and all outputs stay zero.
        repeat (4) rnd_cycle("rst_hold");
        rst_n = 1'b1;

        // Fill every word with known data, two words per cycle.
        for (int a = 0; a < DEPTH; a += 2)
            cycle("init", 1, 4'hF, AW'(a), $urandom(), 1, 4'hF, AW'(a + 1), $urandom());

        // Byte-enable merge.
        cycle("be_w0", 1, 4'hF, 8'h20, 32'hAABBCCDD, 0, 4'h0, 8'h00, 32'h0);
        cycle("be_w1", 1, 4'b0101, 8'h20, 32'h11223344, 0, 4'h0, 8'h00, 32'h0);
        cycle("be_rd", 1, 4'h0, 8'h20, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        chk("be_merge", 64'(od_a[0]), 64'h00000000AA22CC44);
        chk("be_valid", 64'(ov_a[0]), 64'h1);
        idle("be_idle");
        chk("be_merge_oreg", 64'(od_a[1]), 64'h00000000AA22CC44);
        chk("be_valid_oreg", 64'(ov_a[1]), 64'h1);

        // Read-during-write on the writing port.
        cycle("rdw_w0", 1, 4'hF, 8'h30, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        cycle("rdw_w1", 1, 4'hF, 8'h30, 32'hDEADBEEF, 0, 4'h0, 8'h00, 32'h0);
        chk("rdw_wfirst", 64'(od_a[0]), 64'h00000000DEADBEEF);
        chk("rdw_nochg_v", 64'(ov_a[2]), 64'h0);
        idle("rdw_idle");
        chk("rdw_rfirst", 64'(od_a[1]), 64'h0);
        chk("rdw_rfirst_v", 64'(ov_a[1]), 64'h1);

        // Dual write to one address: A wins the shared byte.
        cycle("dw_w0", 1, 4'hF, 8'h50, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        cycle("dw_ww", 1, 4'b0011, 8'h50, 32'h11111111, 1, 4'b0110, 8'h50, 32'h22222222);
        chk("dw_coll", 64'(oc[0]), 64'h1);
        cycle("dw_rd", 1, 4'h0, 8'h50, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        chk("dw_merge", 64'(od_a[0]), 64'h0000000000221111);

        // Cross-port read sees the pre-write word.
        cycle("xp_w0", 1, 4'hF, 8'h40, 32'h5, 0, 4'h0, 8'h00, 32'h0);
        cycle("xp_wr", 1, 4'hF, 8'h40, 32'h9, 1, 4'h0, 8'h40, 32'h0);
        chk("xp_old", 64'(od_b[0]), 64'h5);
        chk("xp_coll", 64'(oc[0]), 64'h1);
        cycle("xp_rd", 0, 4'h0, 8'h00, 32'h0, 1, 4'h0, 8'h40, 32'h0);
        chk("xp_new", 64'(od_b[0]), 64'h9);

        // Random mixed traffic.
        repeat (400) rnd_cycle("rnd");

        // Requests during reset must not disturb the array.
        keep10 = rmem[8'h10];
        rst_n = 1'b0;
        #1 model_clear();
        check_all("rst_async0");
        @(negedge clk);
        repeat (3) cycle("rst_req", 1, 4'hF, 8'h10, $urandom(), 1, 4'hF, 8'h10, $urandom());
        rst_n = 1'b1;
        cycle("rst_rd", 1, 4'h0, 8'h10, 32'h0, 0, 4'h0, 8'h00, 32'h0);
        chk("rst_keep", 64'(od_a[0]), 64'(keep10));

        // Reset mid-stream of back-to-back reads: valid drops at once, and nothing stale follows.
        repeat (4) cycle("mid_rd", 1, 4'h0, AW'($urandom_range(0, DEPTH-1)), 32'h0,
                                   1, 4'h0, AW'($urandom_range(0, DEPTH-1)), 32'h0);
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        check_all("rst_async1");
        chk("rst_async_oreg_v", 64'(ov_a[1]), 64'h0);
        @(negedge clk);
        idle("mid_hold");
        rst_n = 1'b1;
        repeat (3) idle("mid_post");
        repeat (40) rnd_cycle("rnd2");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
